// File: rtl/blk_e9f394.sv
// Two-stage pipelined signed divide by 2^shift, rounding toward zero.
// Produces the truncated quotient and matching remainder with valid/ready on both sides.
module blk_e9f394 #(
   parameter int unsigned N  = 8,
   parameter int unsigned SW = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          arg_vld,
   output logic          arg_rdy,
   input  logic [N-1:0]  arg,
   input  logic [SW-1:0] shift,
   output logic          res_vld,
   input  logic          res_rdy,
   output logic [N-1:0]  quot,
   output logic [N-1:0]  rem
);

   logic                 s1_vld_q, s1_vld_d;
   logic [N-1:0]         s1_arg_q;
   logic [SW-1:0]        s1_sh_q;
   logic [N:0]           s1_biased_q, s1_biased_d;

   logic                 s2_vld_q, s2_vld_d;
   logic [N-1:0]         quot_q, quot_d;
   logic [N-1:0]         rem_q, rem_d;

   logic                 s2_adv;
   logic                 s1_load;
   logic                 s2_load;
   logic [N:0]           mask;
   logic signed [N:0]    shifted;

   always_comb begin
      s2_adv   = !s2_vld_q || res_rdy;
      arg_rdy  = !s1_vld_q || s2_adv;
      s1_load  = arg_vld && arg_rdy;
      s2_load  = s2_adv && s1_vld_q;
      s1_vld_d = arg_rdy ? arg_vld : s1_vld_q;
      s2_vld_d = s2_adv ? s1_vld_q : s2_vld_q;

      // Shifts of N or more saturate to an all-ones N-bit mask; bit N stays clear.
      mask        = ~({(N+1){1'b1}} << shift) & {1'b0, {N{1'b1}}};
      s1_biased_d = {arg[N-1], arg} + (arg[N-1] ? mask : '0);

      shifted = $signed(s1_biased_q) >>> s1_sh_q;
      quot_d  = shifted[N-1:0];
      rem_d   = s1_arg_q - (quot_d << s1_sh_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_vld_q <= 1'b0;
         s2_vld_q <= 1'b0;
         quot_q   <= '0;
         rem_q    <= '0;
      end else begin
         s1_vld_q <= s1_vld_d;
         s2_vld_q <= s2_vld_d;
         if (s2_load) begin
            quot_q <= quot_d;
            rem_q  <= rem_d;
         end
      end
   end

   // Stage-1 payload is qualified by s1_vld_q, so it needs no reset.
   always_ff @(posedge clk) begin
      if (s1_load) begin
         s1_arg_q    <= arg;
         s1_sh_q     <= shift;
         s1_biased_q <= s1_biased_d;
      end
   end

   assign res_vld = s2_vld_q;
   assign quot    = quot_q;
   assign rem     = rem_q;

endmodule

// File: tb/tb_blk_e9f394.sv
// Bench for blk_e9f394: directed edge/backpressure/reset steps plus a randomized
// handshake run, checked against a scoreboard computed with integer / and %.
module tb_blk_e9f394;

   logic       clk = 1'b0;
   logic       rst;
   logic       arg_vld;
   logic       arg_rdy;
   logic [7:0] arg;
   logic [3:0] shift;
   logic       res_vld;
   logic       res_rdy;
   logic [7:0] quot;
   logic [7:0] rem;

   int          npass = 0;
   int          ntot  = 0;
   int          nin   = 0;
   int          nout  = 0;
   logic [15:0] exp_q[$];
   logic [15:0] got[$];

   blk_e9f394 #(.N(8), .SW(4)) dut (
      .clk     (clk),
      .rst     (rst),
      .arg_vld (arg_vld),
      .arg_rdy (arg_rdy),
      .arg     (arg),
      .shift   (shift),
      .res_vld (res_vld),
      .res_rdy (res_rdy),
      .quot    (quot),
      .rem     (rem)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [15:0] model(input logic [7:0] a, input logic [3:0] s);
      int ai, d, q, r;
      ai = int'($signed(a));
      d  = 1 << int'(s);
      q  = ai / d;
      r  = ai % d;
      return {q[7:0], r[7:0]};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntot++;
      assert (obs === exp) npass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic fail_now(input string tag);
      ntot++;
      $error("FAIL %s: observed unexpected event, expected none", tag);
   endtask

   // Called just after a falling edge; drives one cycle and scores both handshakes.
   task automatic cyc(input logic v, input logic [7:0] a, input logic [3:0] s, input logic rr);
      arg_vld = v;
      arg     = a;
      shift   = s;
      res_rdy = rr;
      #1;
      if (res_vld && res_rdy) begin
         nout++;
         got.push_back({quot, rem});
         if (exp_q.size() == 0) fail_now("spurious_result");
         else check("scoreboard", {16'h0, quot, rem}, {16'h0, exp_q.pop_front()});
      end
      if (arg_vld && arg_rdy) begin
         nin++;
         exp_q.push_back(model(a, s));
      end
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 4'h0, 1'b1);
   endtask

   initial begin
      int budget;
      rst     = 1'b1;
      arg_vld = 1'b0;
      arg     = '0;
      shift   = '0;
      res_rdy = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("rst_res_vld", 32'(res_vld), 32'd0);
      check("rst_quot", 32'(quot), 32'd0);
      check("rst_rem", 32'(rem), 32'd0);
      check("rst_arg_rdy", 32'(arg_rdy), 32'd1);

      // Back-to-back stream with two-cycle latency
      got.delete();
      cyc(1'b1, 8'(-9), 4'd2, 1'b1);
      check("lat_edge1", 32'(res_vld), 32'd0);
      cyc(1'b1, 8'(9), 4'd2, 1'b1);
      check("lat_edge2", 32'(res_vld), 32'd1);
      cyc(1'b1, 8'(-1), 4'd3, 1'b1);
      cyc(1'b1, 8'(7), 4'd3, 1'b1);
      idle(4);
      check("stream_count", got.size(), 32'd4);
      check("stream_0", 32'(got[0]), 32'h0000FEFF);
      check("stream_1", 32'(got[1]), 32'h00000201);
      check("stream_2", 32'(got[2]), 32'h000000FF);
      check("stream_3", 32'(got[3]), 32'h00000007);

      // Boundary values, including shifts at and beyond the operand width
      got.delete();
      cyc(1'b1, 8'(-128), 4'd0, 1'b1);
      cyc(1'b1, 8'(-128), 4'd7, 1'b1);
      cyc(1'b1, 8'(127), 4'd7, 1'b1);
      cyc(1'b1, 8'(-127), 4'd7, 1'b1);
      cyc(1'b1, 8'(-5), 4'd9, 1'b1);
      cyc(1'b1, 8'(-128), 4'd15, 1'b1);
      cyc(1'b1, 8'(-1), 4'd8, 1'b1);
      idle(4);
      check("edge_count", got.size(), 32'd7);
      check("edge_m128_s0", 32'(got[0]), 32'h00008000);
      check("edge_m128_s7", 32'(got[1]), 32'h0000FF00);
      check("edge_127_s7", 32'(got[2]), 32'h0000007F);
      check("edge_m127_s7", 32'(got[3]), 32'h00000081);
      check("edge_m5_s9", 32'(got[4]), 32'h000000FB);
      check("edge_m128_s15", 32'(got[5]), 32'h00000080);
      check("edge_m1_s8", 32'(got[6]), 32'h000000FF);

      // Backpressure: outputs hold and the third operand waits
      got.delete();
      cyc(1'b1, 8'(-20), 4'd2, 1'b0);
      cyc(1'b1, 8'(20), 4'd2, 1'b0);
      check("bp_arg_rdy_low", 32'(arg_rdy), 32'd0);
      for (int i = 0; i < 5; i++) begin
         cyc(1'b1, 8'(-3), 4'd1, 1'b0);
         check("bp_hold_vld", 32'(res_vld), 32'd1);
         check("bp_hold_data", {16'h0, quot, rem}, 32'h0000FB00);
         check("bp_hold_rdy", 32'(arg_rdy), 32'd0);
      end
      cyc(1'b1, 8'(-3), 4'd1, 1'b1);
      idle(4);
      check("bp_count", got.size(), 32'd3);
      check("bp_0", 32'(got[0]), 32'h0000FB00);
      check("bp_1", 32'(got[1]), 32'h00000500);
      check("bp_2", 32'(got[2]), 32'h0000FFFF);

      // Randomized operands and handshake toggling
      nin    = 0;
      nout   = 0;
      budget = 0;
      while (nin < 10000 && budget < 40000) begin
         cyc($urandom_range(0, 3) != 0, 8'($urandom), 4'($urandom), $urandom_range(0, 3) != 0);
         budget++;
      end
      if (nin < 10000) fail_now("random_budget");
      budget = 0;
      while (exp_q.size() != 0 && budget < 20) begin
         idle(1);
         budget++;
      end
      if (exp_q.size() != 0) fail_now("random_drain_timeout");
      check("random_in_eq_out", 32'(nout), 32'(nin));

      // Reset with two transactions in flight
      cyc(1'b1, 8'(10), 4'd1, 1'b0);
      cyc(1'b1, 8'(20), 4'd1, 1'b0);
      check("mid_full", 32'(arg_rdy), 32'd0);
      rst     = 1'b1;
      arg_vld = 1'b0;
      res_rdy = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      got.delete();
      check("mid_rst_vld", 32'(res_vld), 32'd0);
      check("mid_rst_quot", 32'(quot), 32'd0);
      check("mid_rst_rem", 32'(rem), 32'd0);
      check("mid_rst_rdy", 32'(arg_rdy), 32'd1);
      idle(3);
      check("mid_no_stale", got.size(), 32'd0);
      cyc(1'b1, 8'(-7), 4'd1, 1'b1);
      check("mid_lat1", 32'(res_vld), 32'd0);
      idle(1);
      check("mid_lat2", 32'(res_vld), 32'd1);
      idle(3);
      check("mid_count", got.size(), 32'd1);
      check("mid_result", 32'(got[0]), 32'h0000FDFF);

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
